uart_tx_frame_sequencer: RTL
============================

Name: uart_tx_frame_sequencer

Overview:
Controller that serialises one multi-byte result block (default 16-byte AES ciphertext) onto the single byte-wide UART transmitter, one byte at a time. It owns the transmitter's start/done handshake, prepends an optional header byte, and enforces an inter-byte gap counted in sample ticks from the TX tick generator. Sits between the AES core output and the UART TX byte engine.

Parameters:
NBYTES, 16, payload bytes per frame (1..255)
HEADER_EN, 1, 1 = send HEADER byte before payload
HEADER, 8'hA5, header byte value
GAP_TICKS, 4, s_tick pulses idled between consecutive bytes (0 = back-to-back)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
blk_valid  in  1  upstream block available
blk_data  in  8*NBYTES  block; byte 0 = bits [8*NBYTES-1 -: 8] (sent first)
blk_ready  out  1  sequencer accepts a block this cycle
abort  in  1  synchronous frame abort
s_tick  in  1  single-cycle sample-tick enable
tx_start  out  1  one-cycle start pulse to UART TX
tx_data  out  8  byte to transmit; stable from tx_start until tx_done_tick
tx_done_tick  in  1  one-cycle pulse: UART TX finished current byte
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last byte completes
frame_cnt  out  8  completed-frame counter

Behaviour:
- Reset (reset=0, async): state IDLE, blk_ready=1, tx_start=0, tx_data=0, busy=0, frame_done=0, frame_cnt=0, shift reg/byte/gap counters=0.
- States: IDLE, SEND, WAIT, GAP, DONE. blk_ready=(state==IDLE); busy=(state!=IDLE); tx_start=(state==SEND); frame_done=(state==DONE). All decoded from the state register, no input-to-output combinational paths.
- IDLE: on blk_valid&&blk_ready at edge N, latch blk_data into the shift reg and clear the byte counter. If HEADER_EN, tx_data=HEADER and a header flag is set; otherwise tx_data=byte 0. Go to SEND; tx_start is high in cycle N+1.
- SEND: lasts exactly one cycle, then WAIT. A tx_done_tick in this cycle is ignored.
- WAIT: hold tx_data. On tx_done_tick:
  - Last byte sent (byte counter==NBYTES-1 and header flag clear): go to DONE.
  - Otherwise: advance (clear the header flag, or shift left 8 and increment the counter), load the next byte into tx_data, clear the gap counter, and go to GAP if GAP_TICKS>0, else SEND.
- GAP: increment the gap counter per s_tick. When count reaches GAP_TICKS, go to SEND. tx_done_tick is ignored.
- DONE: one cycle. frame_cnt+=1 (wraps 255->0), then IDLE.
- Frame length on the wire: NBYTES+HEADER_EN bytes; exactly that many tx_start pulses per accepted block.
- abort (any non-IDLE state): next state IDLE, no frame_done, frame_cnt unchanged, tx_data holds its last value. A byte already started in the UART completes; its tx_done_tick arrives in IDLE and is ignored. abort in IDLE has no effect; abort wins over simultaneous blk_valid.
- blk_valid while busy: not accepted, data not sampled; upstream must hold.
- Async reset mid-frame: immediate return to the reset values above; no further tx_start.
- Counter widths: byte counter 8 bits, gap counter ceil(log2(GAP_TICKS+1)) bits (min 1).

Test Plan:
- Reset released, blk_valid=0 for 20 cycles -> blk_ready=1, busy=0, tx_start never asserted, frame_cnt=0.
- Defaults; block 0x00112233445566778899AABBCCDDEEFF; done pulses 10 cycles after each start -> 17 tx_start pulses, tx_data sequence A5,00,11,...,FF. Each gap contains exactly 4 s_tick pulses. frame_done pulses once; frame_cnt=1.
- HEADER_EN=0, GAP_TICKS=0, NBYTES=2, block 0xBEEF -> tx_data BE then EF. Next tx_start occurs 1 cycle after each tx_done_tick; 2 pulses total.
- blk_valid held with a new block throughout frame 1 -> second block accepted only in the first IDLE cycle after frame_done. Its bytes follow, with no loss or duplication.
- abort asserted in WAIT of byte 5; a stray tx_done_tick then arrives -> state IDLE, no frame_done, frame_cnt unchanged, no further tx_start. Next block sends in full.
- Async reset asserted in GAP mid-frame -> all outputs at reset values same cycle. After release, a new block transmits from the header.
- 256 back-to-back frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/uart_tx_frame_sequencer.sv
// Serialises one NBYTES result block (optional header byte first) onto a byte-wide UART TX,
// owning its start/done handshake and idling GAP_TICKS sample ticks between consecutive bytes.
`timescale 1ns/1ps
module uart_tx_frame_sequencer #(
    parameter int         NBYTES    = 16,
    parameter bit         HEADER_EN = 1'b1,
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int         GAP_TICKS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                blk_valid,
    input  logic [8*NBYTES-1:0] blk_data,
    output logic                blk_ready,
    input  logic                abort,
    input  logic                s_tick,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_done_tick,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          frame_cnt
);

    localparam int DW = 8 * NBYTES;
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [DW-1:0]   shifted;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            hdr_q, hdr_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            hdr_q       <= 1'b0;
            tx_data_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            hdr_q       <= hdr_d;
            tx_data_q   <= tx_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        hdr_d       = hdr_q;
        tx_data_d   = tx_data_q;
        frame_cnt_d = frame_cnt_q;
        // Next payload byte always sits in the top byte once the register is shifted.
        shifted     = shift_q << 8;

        case (state_q)
            S_IDLE: begin
                if (blk_valid && !abort) begin
                    shift_d    = blk_data;
                    byte_cnt_d = '0;
                    hdr_d      = HEADER_EN;
                    tx_data_d  = HEADER_EN ? HEADER : blk_data[DW-1 -: 8];
                    state_d    = S_SEND;
                end
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done_tick) begin
                    if (byte_cnt_q == 8'(NBYTES - 1) && !hdr_q) begin
                        state_d = S_DONE;
                    end else begin
                        if (hdr_q) begin
                            hdr_d     = 1'b0;
                            tx_data_d = shift_q[DW-1 -: 8];
                        end else begin
                            shift_d    = shifted;
                            byte_cnt_d = byte_cnt_q + 8'd1;
                            tx_data_d  = shifted[DW-1 -: 8];
                        end
                        gap_cnt_d = '0;
                        state_d   = (GAP_TICKS > 0) ? S_GAP : S_SEND;
                    end
                end
            end
            S_GAP: begin
                if (s_tick) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    if (gap_cnt_d == GW'(GAP_TICKS)) begin
                        state_d = S_SEND;
                    end
                end
            end
            S_DONE: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops the frame but leaves the last byte on tx_data for the in-flight UART byte.
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            tx_data_d   = tx_data_q;
            frame_cnt_d = frame_cnt_q;
        end
    end

    assign blk_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign tx_start   = (state_q == S_SEND);
    assign frame_done = (state_q == S_DONE);
    assign tx_data    = tx_data_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
